// File: rtl/acss_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acss_clk_pkg
//  Description : Shared types and constants for the acss clock distributor.
//  Revision    : 1.0  initial release
// ============================================================================
package acss_clk_pkg;

    // Default width of the per-channel divide-ratio field.
    localparam int DIVW_DEFAULT = 8;

    // Per-channel run state.
    typedef enum logic [1:0] {
        CH_OFF       = 2'd0,
        CH_RUN       = 2'd1,
        CH_STOP_PEND = 2'd2
    } ch_state_t;

endpackage : acss_clk_pkg
`default_nettype wire

// File: rtl/acss_clk_div_ch.sv
`default_nettype none
// ============================================================================
//  Module      : acss_clk_div_ch
//  Description : One divided-clock channel: run/stop FSM, phase counter,
//                active/shadow divide registers, registered clock and strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module acss_clk_div_ch
    import acss_clk_pkg::*;
#(
    parameter int              DIVW    = DIVW_DEFAULT,
    parameter logic            RST_EN  = 1'b0,
    parameter logic [DIVW-1:0] RST_DIV = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic            en_i,
    input  logic [DIVW-1:0] div_i,
    output logic            clk_o,
    output logic            stb_o,
    output logic            running_o
);

    ch_state_t       state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [DIVW-1:0] div_sh_q, div_sh_d;
    logic            clk_q, clk_d;
    logic            stb_q, stb_d;
    logic            boot_q;

    // State register; boot_q turns a reset-enabled channel into an ordinary start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CH_OFF;
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            div_sh_q <= RST_DIV;
            clk_q    <= 1'b0;
            stb_q    <= 1'b0;
            boot_q   <= RST_EN;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            div_sh_q <= div_sh_d;
            clk_q    <= clk_d;
            stb_q    <= stb_d;
            boot_q   <= 1'b0;
        end
    end

    // Next-state: config handling first, then the phase counter for running states.
    always_comb begin
        ch_state_t nxt;
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        div_sh_d = div_sh_q;
        clk_d    = clk_q;
        stb_d    = 1'b0;
        nxt      = state_q;

        if (we_i) begin
            div_sh_d = div_i;
        end

        case (state_q)
            CH_OFF: begin
                if ((we_i && en_i) || (!we_i && boot_q)) begin
                    state_d = CH_RUN;
                    clk_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    div_d   = we_i ? div_i : div_sh_q;
                end else if (we_i) begin
                    div_d = div_i;
                end
            end
            CH_RUN, CH_STOP_PEND: begin
                if (we_i && !en_i && !clk_q) begin
                    // Disabled while low: truncate the low phase, no edge.
                    state_d = CH_OFF;
                    cnt_d   = '0;
                end else begin
                    if (we_i) begin
                        nxt = en_i ? CH_RUN : CH_STOP_PEND;
                    end
                    if (cnt_q == div_q) begin
                        clk_d = ~clk_q;
                        cnt_d = '0;
                        if (!clk_q) begin
                            // Rising point: the only place a new ratio is adopted.
                            stb_d = 1'b1;
                            div_d = div_sh_q;
                        end else if (nxt == CH_STOP_PEND) begin
                            nxt = CH_OFF;
                        end
                    end else begin
                        cnt_d = cnt_q + DIVW'(1);
                    end
                    state_d = nxt;
                end
            end
            default: begin
                state_d = CH_OFF;
                clk_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign clk_o     = clk_q;
    assign stb_o     = stb_q;
    assign running_o = (state_q != CH_OFF);

endmodule : acss_clk_div_ch
`default_nettype wire

// File: rtl/acss_clk_dist.sv
`default_nettype none
// ============================================================================
//  Module      : acss_clk_dist
//  Description : NCH-channel programmable clock divider/distributor with
//                glitch-free start/stop and divide changes, plus strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module acss_clk_dist
    import acss_clk_pkg::*;
#(
    parameter int              NCH     = 8,
    parameter int              DIVW    = DIVW_DEFAULT,
    parameter logic [NCH-1:0]  RST_EN  = '0,
    parameter logic [DIVW-1:0] RST_DIV = '0
) (
    input  logic                                  SS_CLK,
    input  logic                                  SS_RST,
    input  logic                                  CFG_WE,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CFG_SEL,
    input  logic                                  CFG_EN,
    input  logic [DIVW-1:0]                       CFG_DIV,
    output logic                                  CFG_ACK,
    output logic                                  CFG_ERR,
    output logic [NCH-1:0]                        CLK_OUT,
    output logic [NCH-1:0]                        CLK_STB,
    output logic [NCH-1:0]                        RUNNING
);

    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic w_sel_valid;
    logic ack_q;
    logic err_q;

    // Non-power-of-two NCH leaves encodings that address no channel.
    assign w_sel_valid = (32'(CFG_SEL) < 32'(NCH));

    // Write handshake pulses; reset suppresses the ack of a coincident write.
    always_ff @(posedge SS_CLK) begin
        if (SS_RST) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= CFG_WE &  w_sel_valid;
            err_q <= CFG_WE & ~w_sel_valid;
        end
    end

    assign CFG_ACK = ack_q;
    assign CFG_ERR = err_q;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            logic w_we;
            assign w_we = CFG_WE && w_sel_valid && (CFG_SEL == SELW'(i));

            acss_clk_div_ch #(
                .DIVW    (DIVW),
                .RST_EN  (RST_EN[i]),
                .RST_DIV (RST_DIV)
            ) u_ch (
                .clk       (SS_CLK),
                .rst       (SS_RST),
                .we_i      (w_we),
                .en_i      (CFG_EN),
                .div_i     (CFG_DIV),
                .clk_o     (CLK_OUT[i]),
                .stb_o     (CLK_STB[i]),
                .running_o (RUNNING[i])
            );
        end
    endgenerate

endmodule : acss_clk_dist
`default_nettype wire

// File: tb/tb_acss_clk_dist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acss_clk_dist
//  Description : Directed self-checking bench for acss_clk_dist.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_acss_clk_dist;

    logic       r_clk;
    logic       r_rst;
    logic       r_we;
    logic [2:0] r_sel;
    logic       r_en;
    logic [7:0] r_div;
    logic       w_ack, w_err;
    logic [7:0] w_clk, w_stb, w_run;

    // Second, smaller instance: NCH=6 leaves CFG_SEL codes 6 and 7 unused.
    logic       r_bwe;
    logic [2:0] r_bsel;
    logic       w_back, w_berr;
    logic [5:0] w_bclk, w_bstb, w_brun;

    int n_checks;
    int n_errors;

    acss_clk_dist #(
        .NCH     (8),
        .DIVW    (8),
        .RST_EN  (8'h01),
        .RST_DIV (8'd1)
    ) u_dut (
        .SS_CLK  (r_clk),
        .SS_RST  (r_rst),
        .CFG_WE  (r_we),
        .CFG_SEL (r_sel),
        .CFG_EN  (r_en),
        .CFG_DIV (r_div),
        .CFG_ACK (w_ack),
        .CFG_ERR (w_err),
        .CLK_OUT (w_clk),
        .CLK_STB (w_stb),
        .RUNNING (w_run)
    );

    acss_clk_dist #(
        .NCH     (6),
        .DIVW    (4),
        .RST_EN  (6'h00),
        .RST_DIV (4'd0)
    ) u_dut_b (
        .SS_CLK  (r_clk),
        .SS_RST  (r_rst),
        .CFG_WE  (r_bwe),
        .CFG_SEL (r_bsel),
        .CFG_EN  (1'b1),
        .CFG_DIV (4'd0),
        .CFG_ACK (w_back),
        .CFG_ERR (w_berr),
        .CLK_OUT (w_bclk),
        .CLK_STB (w_bstb),
        .RUNNING (w_brun)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample point sits 1 ns after the rising edge.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic cfg_write(input int sel, input logic en, input logic [7:0] div);
        r_we  = 1'b1;
        r_sel = sel[2:0];
        r_en  = en;
        r_div = div;
        tick();
        r_we  = 1'b0;
    endtask

    // Record n cycles of one channel, first cycle in the MSB position.
    task automatic sample(input int ch, input int n,
                          output logic [31:0] cp, output logic [31:0] sp,
                          output logic [31:0] rp);
        cp = '0;
        sp = '0;
        rp = '0;
        for (int k = 0; k < n; k++) begin
            cp = {cp[30:0], w_clk[ch]};
            sp = {sp[30:0], w_stb[ch]};
            rp = {rp[30:0], w_run[ch]};
            tick();
        end
    endtask

    initial begin
        logic [31:0] cp, sp, rp;
        n_checks = 0;
        n_errors = 0;
        r_rst  = 1'b1;
        r_we   = 1'b0;
        r_sel  = 3'd0;
        r_en   = 1'b0;
        r_div  = 8'd0;
        r_bwe  = 1'b0;
        r_bsel = 3'd0;

        // Reset state
        tick(); tick(); tick();
        check("rst_clk", 32'(w_clk), 32'h0);
        check("rst_stb", 32'(w_stb), 32'h0);
        check("rst_run", 32'(w_run), 32'h0);
        check("rst_ack_err", {30'd0, w_ack, w_err}, 32'h0);

        // Reset-enabled ch0 starts on first cycle after release, DIV=1
        r_rst = 1'b0;
        tick();
        sample(0, 8, cp, sp, rp);
        check("ch0_clk", cp, 32'b11001100);
        check("ch0_stb", sp, 32'b10001000);
        check("ch0_others_idle", 32'(w_run & 8'hFE), 32'h0);

        // Start ch3 DIV=2: period 6, one strobe per period
        cfg_write(3, 1'b1, 8'd2);
        check("ch3_ack", {30'd0, w_ack, w_err}, 32'h2);
        sample(3, 12, cp, sp, rp);
        check("ch3_clk", cp, 32'b111000111000);
        check("ch3_stb", sp, 32'b100000100000);
        check("ack_pulse", 32'(w_ack), 32'h0);

        // Divide change to 0 in mid-high phase
        tick();
        cfg_write(3, 1'b1, 8'd0);
        check("chg_ack", 32'(w_ack), 32'h1);
        sample(3, 10, cp, sp, rp);
        check("chg_clk", cp, 32'b1000101010);
        check("chg_stb", sp, 32'b0000101010);

        // Back to DIV=2, then disable at high-phase cnt=0
        cfg_write(3, 1'b1, 8'd2);
        tick();
        check("pre_dis_high", 32'(w_clk[3]), 32'h1);
        cfg_write(3, 1'b0, 8'd2);
        sample(3, 4, cp, sp, rp);
        check("dis_hi_clk", cp, 32'b1100);
        check("dis_hi_run", rp, 32'b1100);
        check("dis_hi_stb", sp, 32'b0000);

        // Disable during low phase
        cfg_write(3, 1'b1, 8'd2);
        sample(3, 3, cp, sp, rp);
        check("dis_lo_pre_clk", cp, 32'b111);
        check("dis_lo_low", {30'd0, w_clk[3], w_run[3]}, 32'b01);
        cfg_write(3, 1'b0, 8'd2);
        sample(3, 4, cp, sp, rp);
        check("dis_lo_clk", cp, 32'b0000);
        check("dis_lo_run", rp, 32'b0000);
        check("dis_lo_stb", sp, 32'b0000);

        // Disable then re-enable within the high phase
        cfg_write(3, 1'b1, 8'd2);
        cfg_write(3, 1'b0, 8'd2);
        cfg_write(3, 1'b1, 8'd2);
        sample(3, 11, cp, sp, rp);
        check("reen_clk", cp, 32'b10001110001);
        check("reen_stb", sp, 32'b00001000001);
        check("reen_run", rp, 32'b11111111111);
        check("main_no_err", 32'(w_err), 32'h0);

        // Unaddressed channel codes on the 6-channel instance
        check("b_idle", {20'd0, w_brun, w_bclk}, 32'h0);
        r_bwe  = 1'b1;
        r_bsel = 3'd7;
        tick();
        r_bsel = 3'd6;
        check("b_err7", {30'd0, w_back, w_berr}, 32'h1);
        tick();
        r_bwe = 1'b0;
        check("b_err6", {30'd0, w_back, w_berr}, 32'h1);
        check("b_nochange", {20'd0, w_brun, w_bclk}, 32'h0);
        r_bwe  = 1'b1;
        r_bsel = 3'd5;
        tick();
        r_bwe = 1'b0;
        check("b_valid_ack", {30'd0, w_back, w_berr}, 32'h2);
        check("b_ch5_start", 32'(w_bclk), 32'h20);

        // Reset with a coincident write while 4 channels run
        cfg_write(1, 1'b1, 8'd1);
        cfg_write(2, 1'b1, 8'd1);
        check("four_running", 32'(w_run), 32'h0F);
        r_rst = 1'b1;
        r_we  = 1'b1;
        r_sel = 3'd5;
        r_en  = 1'b1;
        r_div = 8'd3;
        tick();
        r_we = 1'b0;
        check("rstw_clk", 32'(w_clk), 32'h0);
        check("rstw_run", 32'(w_run), 32'h0);
        check("rstw_ack", {30'd0, w_ack, w_err}, 32'h0);
        r_rst = 1'b0;
        tick();
        check("rel_clk", 32'(w_clk), 32'h01);
        check("rel_stb", 32'(w_stb), 32'h01);
        check("rel_run", 32'(w_run), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_acss_clk_dist
`default_nettype wire
